feature_vector_builder: RTL

- Producer side of the logistic-regression inner-product stage. Collects a serial stream of 32-bit pixel/feature samples from the line buffer into a full feature vector of N_FEAT words.
- x[0] = bias constant; x[1] = constant 0; x[2..N_FEAT-1] = stream samples.
- Presents the packed vector to the combinational inner-product block under a valid/ready handshake, holding it stable until consumed.

---
 rtl/feature_vector_builder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/feature_vector_builder.sv
// Feature vector builder: gathers N_FEAT-2 stream samples behind a fixed bias/zero pair.
// Optional macro FVB_SLIDING_EN selects a stride-1 sliding window instead of block fill.
module feature_vector_builder #(
   parameter int DATA_W   = 32,
   parameter int N_FEAT   = 41,
   parameter int BIAS_VAL = 1,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [DATA_W-1:0]        pix_data,
   input  logic                     pix_last,
   output logic                     vec_valid,
   input  logic                     vec_ready,
   output logic [N_FEAT*DATA_W-1:0] xarray,
   output logic                     frame_err,
   output logic [CNT_W-1:0]         vec_count
);

   localparam int N_SAMP = N_FEAT - 2;
   localparam int CW     = $clog2(N_SAMP + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMP - 1);

   logic [N_SAMP-1:0][DATA_W-1:0] samp_q, samp_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [CNT_W-1:0]              vcnt_q, vcnt_d;
   logic                          accept;
   logic                          handoff;

   assign accept    = pix_valid && pix_ready;
   assign handoff   = vec_valid && vec_ready;
   assign xarray    = {samp_q, DATA_W'(0), DATA_W'(BIAS_VAL)};
   assign vec_count = vcnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q <= '0;
         cnt_q  <= '0;
         vcnt_q <= '0;
      end else begin
         samp_q <= samp_d;
         cnt_q  <= cnt_d;
         vcnt_q <= vcnt_d;
      end
   end

`ifdef FVB_SLIDING_EN
   logic vvalid_q, vvalid_d;

   assign pix_ready = !vvalid_q || vec_ready;
   assign vec_valid = vvalid_q;
   assign frame_err = 1'b0;

   // The fill count saturates at N_SAMP; once the window is full every accept yields a vector.
   always_comb begin
      samp_d   = samp_q;
      cnt_d    = cnt_q;
      vvalid_d = vvalid_q;
      vcnt_d   = vcnt_q;
      if (handoff) begin
         vvalid_d = 1'b0;
         vcnt_d   = vcnt_q + 1'b1;
      end
      if (accept) begin
         samp_d   = {pix_data, samp_q[N_SAMP-1:1]};
         vvalid_d = (cnt_q >= LAST_IDX);
         if (pix_last)
            cnt_d = '0;
         else if (cnt_q != CW'(N_SAMP))
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vvalid_q <= 1'b0;
      else
         vvalid_q <= vvalid_d;
   end
`else
   typedef enum logic {FILL, HOLD} state_t;

   state_t state_q, state_d;
   logic   err_q, err_d;

   assign pix_ready = (state_q == FILL);
   assign vec_valid = (state_q == HOLD);
   assign frame_err = err_q;

   // An early pix_last drops its sample and restarts the fill; stale elements are never presented.
   always_comb begin
      state_d = state_q;
      samp_d  = samp_q;
      cnt_d   = cnt_q;
      vcnt_d  = vcnt_q;
      err_d   = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               if (pix_last && (cnt_q != LAST_IDX)) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  samp_d[cnt_q] = pix_data;
                  if (cnt_q == LAST_IDX) begin
                     state_d = HOLD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            if (handoff) begin
               state_d = FILL;
               cnt_d   = '0;
               vcnt_d  = vcnt_q + 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end
`endif

endmodule
